branch_predictor: RTL and testbench

IF-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Lookup is combinational on PC_IF. It produces predict_taken and predict_target, which the IF/ID pipeline register captures alongside PC_IF.
- The EX stage resolves each branch and feeds the result back here. This block trains the tables and raises mispredict/redirect_PC for the front end.
- It is the producing end of the predict_taken signal that travels IF -> ID -> EX.

---
 rtl/branch_predictor.sv | 98 +++++++++
 tb/tb_branch_predictor.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit counters.
// Combinational lookup on PC_IF, trained by EX resolutions.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_IF,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_PC,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_PC,
  output logic [31:0] perf_mispredicts
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr;
  logic [1:0]       up_ctr_nxt;

  assign lk_idx = PC_IF[IDX_W+1:2];
  assign lk_tag = PC_IF[31:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign predict_taken  = lk_hit && ctr_q[lk_idx][1];
  assign predict_target = predict_taken ? target_q[lk_idx]
                                        : PC_IF + 32'd4;

  assign up_idx = upd_PC[IDX_W+1:2];
  assign up_tag = upd_PC[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    up_ctr_nxt = up_ctr;
    unique case (1'b1)
      upd_taken && (up_ctr != 2'b11):  up_ctr_nxt = up_ctr + 2'd1;
      !upd_taken && (up_ctr != 2'b00): up_ctr_nxt = up_ctr - 2'd1;
      default:                         up_ctr_nxt = up_ctr;
    endcase
  end

  assign mispredict = rst_n && upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && upd_pred_taken &&
      (upd_target != upd_pred_target)));

  assign redirect_PC = upd_taken ? upd_target : upd_PC + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      target_q[up_idx] <= upd_target;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mispredicts <= '0;
    end else if (mispredict && (perf_mispredicts != 32'hFFFF_FFFF)) begin
      perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Inputs change 1ns after the rising edge; outputs checked 1ns later.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_IF;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        upd_valid;
  logic [31:0] upd_PC;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_PC;
  logic [31:0] perf_mispredicts;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PC_IF           (PC_IF),
    .predict_taken   (predict_taken),
    .predict_target  (predict_target),
    .upd_valid       (upd_valid),
    .upd_PC          (upd_PC),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_PC     (redirect_PC),
    .perf_mispredicts(perf_mispredicts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_PC          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    PC_IF = 32'h40;
    idle();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    upd_valid = 1'b0;
    #2;
    checks++;
    if (predict_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_taken got %b want 0", predict_taken);
    end
    checks++;
    if (predict_target !== 32'h44) begin
      errors++;
      $display("FAIL rst_target got %h want 00000044", predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'h0) begin
      errors++;
      $display("FAIL rst_perf got %h want 0", perf_mispredicts);
    end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_allocate();
    drive(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++;
      $display("FAIL alloc_misp got %b want 1", mispredict);
    end
    checks++;
    if (redirect_PC !== 32'h100) begin
      errors++;
      $display("FAIL alloc_redir got %h want 00000100", redirect_PC);
    end
    tick();
    idle();
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
      errors++;
      $display("FAIL alloc_pred got %b/%h want 1/00000100",
               predict_taken, predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'd1) begin
      errors++;
      $display("FAIL alloc_perf got %0d want 1", perf_mispredicts);
    end
  endtask

  task automatic test_train();
    for (int i = 0; i < 2; i++) begin
      drive(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      #1;
      checks++;
      if (mispredict !== 1'b0) begin
        errors++;
        $display("FAIL train_tk%0d_misp got %b want 0", i, mispredict);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      #1;
      checks++;
      if (mispredict !== 1'b1 || redirect_PC !== 32'h44) begin
        errors++;
        $display("FAIL train_nt%0d got %b/%h want 1/00000044",
                 i, mispredict, redirect_PC);
      end
      tick();
      idle();
      #1;
      checks++;
      if (predict_taken !== (i == 0)) begin
        errors++;
        $display("FAIL train_nt%0d_pred got %b want %b",
                 i, predict_taken, (i == 0));
      end
    end
    checks++;
    if (predict_target !== 32'h44 || perf_mispredicts !== 32'd3) begin
      errors++;
      $display("FAIL train_end got %h/%0d want 00000044/3",
               predict_target, perf_mispredicts);
    end
  endtask

  task automatic test_alias();
    drive(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    drive(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    tick();
    idle();
    PC_IF = 32'h40;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      errors++;
      $display("FAIL alias_40 got %b/%h want 0/00000044",
               predict_taken, predict_target);
    end
    PC_IF = 32'h80;
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
      errors++;
      $display("FAIL alias_80 got %b/%h want 1/00000200",
               predict_taken, predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'd5) begin
      errors++;
      $display("FAIL alias_perf got %0d want 5", perf_mispredicts);
    end
  endtask

  task automatic test_target_change();
    drive(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    drive(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();
    drive(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
    #1;
    checks++;
    if (mispredict !== 1'b1 || redirect_PC !== 32'h180) begin
      errors++;
      $display("FAIL tgt_misp got %b/%h want 1/00000180",
               mispredict, redirect_PC);
    end
    tick();
    idle();
    PC_IF = 32'h40;
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h180) begin
      errors++;
      $display("FAIL tgt_pred got %b/%h want 1/00000180",
               predict_taken, predict_target);
    end
    PC_IF = 32'h43;
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h180) begin
      errors++;
      $display("FAIL tgt_lowbits got %b/%h want 1/00000180",
               predict_taken, predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'd7) begin
      errors++;
      $display("FAIL tgt_perf got %0d want 7", perf_mispredicts);
    end
  endtask

  task automatic test_miss_not_taken();
    drive(32'hC0, 1'b0, 32'h500, 1'b0, 32'hC4);
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++;
      $display("FAIL mnt_misp got %b want 0", mispredict);
    end
    tick();
    idle();
    PC_IF = 32'hC0;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'hC4) begin
      errors++;
      $display("FAIL mnt_pred got %b/%h want 0/000000c4",
               predict_taken, predict_target);
    end
    PC_IF = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (predict_target !== 32'h0) begin
      errors++;
      $display("FAIL wrap got %h want 00000000", predict_target);
    end
  endtask

  task automatic test_same_cycle();
    PC_IF = 32'h40;
    drive(32'h40, 1'b1, 32'h300, 1'b1, 32'h180);
    #1;
    checks++;
    if (predict_target !== 32'h180 || mispredict !== 1'b1) begin
      errors++;
      $display("FAIL same_old got %h/%b want 00000180/1",
               predict_target, mispredict);
    end
    tick();
    idle();
    #1;
    checks++;
    if (predict_target !== 32'h300) begin
      errors++;
      $display("FAIL same_new got %h want 00000300", predict_target);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h104, 1'b0, 32'h0, 1'b1, 32'h700);
    repeat (3) tick();
    idle();
    #1;
    checks++;
    if (perf_mispredicts !== 32'd11) begin
      errors++;
      $display("FAIL b2b_perf got %0d want 11", perf_mispredicts);
    end
  endtask

  task automatic test_async_reset();
    PC_IF = 32'h40;
    drive(32'h40, 1'b0, 32'h0, 1'b1, 32'h300);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      errors++;
      $display("FAIL arst_pred got %b/%h want 0/00000044",
               predict_taken, predict_target);
    end
    checks++;
    if (perf_mispredicts !== 32'h0 || mispredict !== 1'b0) begin
      errors++;
      $display("FAIL arst_perf got %h/%b want 0/0",
               perf_mispredicts, mispredict);
    end
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      errors++;
      $display("FAIL arst_after got %b want 0", predict_taken);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_train();
    test_alias();
    test_target_change();
    test_miss_not_taken();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
